// File: rtl/spi_mem_pkg.sv
// Shared constants and state encoding for the SPI memory responder.
package spi_mem_pkg;

   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam int         ADDR_BITS = 24;

   typedef enum logic [2:0] {
      WAIT_CS,
      IDLE,
      CMD,
      ADDR,
      RD_DATA,
      WR_DATA,
      IGNORE
   } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one SPI pin with rise/fall pulses on the
// synchronized level. The chain resets low, so a pin that is really high
// must propagate through before it is seen as high.
module spi_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES:0]   chain;
   logic                   prev_q;

   assign chain  = {sync_q, pin_i};
   assign sync_o = chain[SYNC_STAGES];
   assign rise_o = sync_o & ~prev_q;
   assign fall_o = ~sync_o & prev_q;

   // Shift the pin through the synchronizer and remember the last level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= chain[SYNC_STAGES-1:0];
         prev_q <= sync_o;
      end
   end

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 target emulating a flash/RAM: READ/WRITE with 24-bit address,
// streaming bytes to/from a local byte-wide memory with auto-increment.
module spi_mem_responder
   import spi_mem_pkg::*;
#(
   parameter int MEM_ADDR_W  = 12,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  spi_sclk_i,
   input  logic                  spi_cs_n_i,
   input  logic                  spi_mosi_i,
   output logic                  spi_miso_o,
   output logic [MEM_ADDR_W-1:0] mem_addr_o,
   output logic                  mem_rd_en_o,
   input  logic [7:0]            mem_rd_data_i,
   output logic                  mem_wr_en_o,
   output logic [7:0]            mem_wr_data_o,
   output logic                  busy_o,
   output logic                  cmd_err_o
);

   localparam logic [4:0] BYTE_LAST = 5'd7;
   localparam logic [4:0] ADDR_LAST = 5'(ADDR_BITS - 1);

   logic sclk_rise, sclk_fall, sclk_unused_lvl;
   logic cs_s, cs_fall, cs_unused_rise;
   logic mosi_s, mosi_unused_rise, mosi_unused_fall;

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
      .clk(clk), .rst_n(rst_n), .pin_i(spi_sclk_i),
      .sync_o(sclk_unused_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
      .clk(clk), .rst_n(rst_n), .pin_i(spi_cs_n_i),
      .sync_o(cs_s), .rise_o(cs_unused_rise), .fall_o(cs_fall));

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
      .clk(clk), .rst_n(rst_n), .pin_i(spi_mosi_i),
      .sync_o(mosi_s), .rise_o(mosi_unused_rise), .fall_o(mosi_unused_fall));

   state_e                 state_q, state_d;
   logic [4:0]             cnt_q, cnt_d;
   logic [7:0]             sh_q, sh_d, sh_nxt;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   logic                   rd_flag_q, rd_flag_d;
   logic [7:0]             tx_q, tx_d;
   logic                   miso_q, miso_d;
   logic                   rd_en_q, rd_en_d;
   logic                   wr_en_q, wr_en_d;
   logic [7:0]             wr_data_q, wr_data_d;
   logic                   cmd_err_q, cmd_err_d;
   logic                   ld_pend_q, ld_pend_d;   // read data arrives this cycle
   logic                   inc_pend_q, inc_pend_d; // bump address after a write

   assign spi_miso_o    = miso_q;
   assign mem_addr_o    = addr_q[MEM_ADDR_W-1:0];
   assign mem_rd_en_o   = rd_en_q;
   assign mem_wr_en_o   = wr_en_q;
   assign mem_wr_data_o = wr_data_q;
   assign cmd_err_o     = cmd_err_q;
   assign busy_o        = (state_q != IDLE) && (state_q != WAIT_CS);

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= WAIT_CS;
         cnt_q      <= '0;
         sh_q       <= '0;
         addr_q     <= '0;
         rd_flag_q  <= 1'b0;
         tx_q       <= '0;
         miso_q     <= 1'b0;
         rd_en_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_data_q  <= '0;
         cmd_err_q  <= 1'b0;
         ld_pend_q  <= 1'b0;
         inc_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         addr_q     <= addr_d;
         rd_flag_q  <= rd_flag_d;
         tx_q       <= tx_d;
         miso_q     <= miso_d;
         rd_en_q    <= rd_en_d;
         wr_en_q    <= wr_en_d;
         wr_data_q  <= wr_data_d;
         cmd_err_q  <= cmd_err_d;
         ld_pend_q  <= ld_pend_d;
         inc_pend_q <= inc_pend_d;
      end
   end

   // Next-state, bit collection, memory strobes and MISO shifting.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      addr_d     = addr_q;
      rd_flag_d  = rd_flag_q;
      tx_d       = tx_q;
      miso_d     = miso_q;
      rd_en_d    = 1'b0;
      wr_en_d    = 1'b0;
      wr_data_d  = wr_data_q;
      cmd_err_d  = 1'b0;
      ld_pend_d  = rd_en_q;
      inc_pend_d = 1'b0;
      sh_nxt     = {sh_q[6:0], mosi_s};

      if (inc_pend_q) addr_d = addr_q + 24'd1;
      if (ld_pend_q)  tx_d   = mem_rd_data_i;

      // cs_n high aborts everything, including a same-cycle 8th-bit strobe.
      if (state_q != WAIT_CS && cs_s) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            WAIT_CS: if (cs_s) state_d = IDLE;
            IDLE: if (cs_fall) begin
               state_d = CMD;
               cnt_d   = '0;
            end
            CMD: if (sclk_rise) begin
               sh_d  = sh_nxt;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == BYTE_LAST) begin
                  cnt_d = '0;
                  if (sh_nxt == CMD_READ) begin
                     state_d   = ADDR;
                     rd_flag_d = 1'b1;
                  end else if (sh_nxt == CMD_WRITE) begin
                     state_d   = ADDR;
                     rd_flag_d = 1'b0;
                  end else begin
                     state_d   = IGNORE;
                     cmd_err_d = 1'b1;
                  end
               end
            end
            ADDR: if (sclk_rise) begin
               addr_d = {addr_q[ADDR_BITS-2:0], mosi_s};
               cnt_d  = cnt_q + 5'd1;
               if (cnt_q == ADDR_LAST) begin
                  cnt_d = '0;
                  if (rd_flag_q) begin
                     rd_en_d = 1'b1;
                     state_d = RD_DATA;
                  end else begin
                     state_d = WR_DATA;
                  end
               end
            end
            RD_DATA: begin
               if (sclk_fall) begin
                  miso_d = tx_q[7];
                  tx_d   = {tx_q[6:0], 1'b0};
               end
               if (sclk_rise) begin
                  cnt_d = cnt_q + 5'd1;
                  if (cnt_q == BYTE_LAST) begin
                     // Prefetch the next byte while the master finishes this one.
                     cnt_d   = '0;
                     addr_d  = addr_q + 24'd1;
                     rd_en_d = 1'b1;
                  end
               end
            end
            WR_DATA: if (sclk_rise) begin
               sh_d  = sh_nxt;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == BYTE_LAST) begin
                  cnt_d      = '0;
                  wr_en_d    = 1'b1;
                  wr_data_d  = sh_nxt;
                  inc_pend_d = 1'b1;
               end
            end
            default: ;
         endcase
      end

      if (state_d != RD_DATA) miso_d = 1'b0;
   end

endmodule

// File: doc/spi_mem_responder.md
# spi_mem_responder

SPI-mode-0 target that answers the CPU's external-memory SPI master and stands in for a flash/RAM chip. It decodes READ (0x03) and WRITE (0x02) commands with a 24-bit address, then streams bytes to or from a local synchronous byte-wide memory port, auto-incrementing the address. It sits on one chip-select line, either the flash or the RAM select, and its pins are oversampled by the system clock.

## Interface
Parameters:
- MEM_ADDR_W, default 12: width of the local memory address; the low MEM_ADDR_W bits of the 24-bit SPI address.
- SYNC_STAGES, default 2: synchronizer depth on spi_sclk, spi_cs_n and spi_mosi.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- spi_sclk  in  1  SPI clock from the master; idles low.
- spi_cs_n  in  1  chip select, active-low.
- spi_mosi  in  1  master-to-target data.
- spi_miso  out  1  target-to-master data; driven 0 when not in a read data phase. Never tri-stated.
- mem_addr  out  MEM_ADDR_W  local memory address.
- mem_rd_en  out  1  one-cycle read strobe.
- mem_rd_data  in  8  read data; valid exactly 1 clk after mem_rd_en.
- mem_wr_en  out  1  one-cycle write strobe.
- mem_wr_data  out  8  write data; qualified by mem_wr_en.
- busy  out  1  high while a transaction is in progress, i.e. not IDLE and not WAIT_CS.
- cmd_err  out  1  one-cycle pulse when an unknown command byte is received.

## Operation
- Pins pass through SYNC_STAGES flops. Edges are detected on the synchronized sclk.
- MOSI is sampled on each sclk rising edge. MISO is updated on each sclk falling edge. Bit order is MSB first.
- State machine:
  - WAIT_CS: entered on reset. Goes to IDLE once cs_n is seen high.
  - IDLE: goes to CMD on a cs_n falling edge.
  - CMD: collects 8 bits.
    - 0x03 goes to ADDR with read flag set.
    - 0x02 goes to ADDR with write flag set.
    - Any other value pulses cmd_err and goes to IGNORE.
  - ADDR: collects 24 bits into addr_q.
    - On the 24th rising edge, a read transaction issues mem_rd_en for addr_q and goes to RD_DATA.
    - A write transaction goes to WR_DATA.
  - RD_DATA:
    - The tx shifter loads mem_rd_data 1 clk after mem_rd_en.
    - On each falling edge, spi_miso = shifter[7] and the shifter shifts left.
    - On the 8th rising edge of a byte, addr_q increments and mem_rd_en is issued for the new address (prefetch).
  - WR_DATA:
    - Shifts in 8 bits.
    - On the 8th rising edge, pulses mem_wr_en with mem_wr_data = the assembled byte and mem_addr = addr_q.
    - addr_q increments the cycle after the write.
  - IGNORE: no memory activity; spi_miso = 0.
- From any state except WAIT_CS, a synchronized cs_n high returns to IDLE.
  - A partially received write byte is discarded; no mem_wr_en is issued.
  - The bit counter clears.
- addr_q is a 24-bit counter and wraps 0xFFFFFF → 0x000000. mem_addr = addr_q[MEM_ADDR_W-1:0], so local aliasing is expected.
- Wire byte order: the first data byte is at the lowest address. A 4-byte master read of address A returns {M[A], M[A+1], M[A+2], M[A+3]} in wire order.

## Timing
- Requirement on the master: sclk high and low phases each ≥ 4 clk cycles, and cs_n setup/hold ≥ 4 clk cycles around the first/last sclk edge. Behaviour is undefined otherwise.
- Edge detection latency is SYNC_STAGES+1 clk from the pin.
- Read path:
  - mem_rd_en is asserted the clk after the 24th (or 8th data) rising edge is detected.
  - The shifter loads at +2.
  - The first data bit appears on spi_miso at the detected falling edge. That edge is ≥ 4 clk after the rising edge, so the data is ready.
- A write strobe is asserted exactly 1 clk after the 8th data rising edge is detected.
- Reset values: spi_miso=0, mem_rd_en=0, mem_wr_en=0, mem_wr_data=0, mem_addr=0, busy=0, cmd_err=0. State is WAIT_CS.
- Reset asserted mid-transaction: all of the above apply on the next clk. The block stays in WAIT_CS until cs_n is high, so the rest of the interrupted frame is ignored.
- If cs_n rises on the same clk as an 8th-bit rising edge, cs_n wins: no mem strobe is issued.

## Structure
- Package spi_mem_pkg holds:
  - CMD_READ = 8'h03 and CMD_WRITE = 8'h02;
  - the state enum (WAIT_CS, IDLE, CMD, ADDR, RD_DATA, WR_DATA, IGNORE);
  - the ADDR_BITS = 24 constant.
- Sub-module spi_pin_sync: SYNC_STAGES synchronizer plus rise/fall pulse outputs. It is instantiated for sclk and cs_n; mosi uses its synchronizer only.

## Test plan
- Preload M[0x010..0x013] = 0xDE, 0xAD, 0xBE, 0xEF. Master sends 0x03, 0x000010, then clocks 32 bits → MISO yields 0xDEADBEEF. 4 mem_rd_en pulses at 0x010..0x013 (a 5th prefetch at 0x014 is allowed).
- Master sends 0x02, 0x000020, 0xA5, 0x5A → mem_wr_en pulses at 0x020 with 0xA5 and 0x021 with 0x5A. Read-back returns 0xA55A.
- Master sends 0x02, 0x000030, then 5 bits, then raises cs_n → no mem_wr_en. Next transaction decodes normally.
- Master sends command 0x9F → cmd_err pulses once, MISO stays 0 for the rest of the frame, no memory strobes.
- Master reads 2 bytes at 0xFFFFFF → bytes come from addr_q 0xFFFFFF then 0x000000; mem_addr is 0xFFF then 0x000 for MEM_ADDR_W=12.
- rst_n pulsed low during the address phase → all outputs 0. Following bits are ignored until cs_n goes high. The next full frame works.
